// File: rtl/alu32_pkg.sv
// Shared definitions for the ALU32 serial datapath: FSM state type, default sizes
// and counter sizing helpers.
package alu32_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CHUNK = 4;

    // Counter must hold N-1 and never be zero width.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned N     = DEF_WIDTH / DEF_CHUNK;
    localparam int unsigned CNT_W = cnt_width(N);

endpackage

// File: rtl/serial_subtractor32_fs_cell.sv
// 1-bit combinational full subtractor: d = x - y - bi, bo = borrow out.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor32.sv
// Multi-cycle subtractor computing a - b - bin, CHUNK bits per clock, LSB chunk first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor32
    import alu32_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NUM = WIDTH / CHUNK;
    localparam int unsigned CW  = cnt_width(NUM);

    if ((CHUNK == 0) || (WIDTH % CHUNK != 0)) begin : g_chunk_check
        $error("serial_subtractor32: CHUNK must be nonzero and divide WIDTH");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] chunk_d;
    logic [CHUNK:0]   brw;
    logic [WIDTH-1:0] next_diff;

    assign brw[0] = borrow;

    for (genvar i = 0; i < CHUNK; i++) begin : g_cell
        fs_cell u_fs (
            .x  (a_sr[i]),
            .y  (b_sr[i]),
            .bi (brw[i]),
            .d  (chunk_d[i]),
            .bo (brw[i+1])
        );
    end

    // New chunk enters at the top; after N shifts the LSB chunk sits at bit 0.
    assign next_diff = WIDTH'({chunk_d, diff_sr} >> CHUNK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            zero    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> CHUNK;
                    b_sr    <= b_sr >> CHUNK;
                    diff_sr <= next_diff;
                    borrow  <= brw[CHUNK];
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(NUM - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= next_diff;
                        bout  <= brw[CHUNK];
                        zero  <= (next_diff == '0);
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= brw[CHUNK] ^ brw[CHUNK-1];
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor32.sv
// Directed bench for serial_subtractor32: vector table plus handshake and reset sequences.
// Define SERIAL_SUB_OVF_EN to also check ovf.
module tb_serial_subtractor32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [31:0] diff;
    logic        bout;
    logic        zero;
`ifdef SERIAL_SUB_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor32 #(.WIDTH(32), .CHUNK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] diff;
        logic        bout;
        logic        zero;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one start pulse; returns at the falling edge after the accepting edge.
    task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic bi);
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // cyc counts falling edges since the accepting edge (first one = 1).
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cnt++;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no done, expected done within 40 cycles");
        end
    endtask

    vec_t vecs[7];

    initial begin
        int cyc;
        int bcnt;
        int dcnt;
        logic [31:0] seen;

        vecs[0] = '{32'd5,        32'd3,        1'b0, 32'd2,        1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'd3,        32'd5,        1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'd0,        32'd0,        1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0,        1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'h80000000, 32'd1,        1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h12345678, 32'd1,        1'b1, 32'h12345676, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", diff, 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].bin);
            wait_done(cyc, bcnt);
            check($sformatf("v%0d_latency", i), 32'(cyc), 32'd9);
            check($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'd8);
            check($sformatf("v%0d_diff", i), diff, vecs[i].diff);
            check($sformatf("v%0d_bout", i), 32'(bout), 32'(vecs[i].bout));
            check($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].zero));
`ifdef SERIAL_SUB_OVF_EN
            check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
`endif
            @(negedge clk);
            check($sformatf("v%0d_done_width", i), 32'(done), 32'd0);
            check($sformatf("v%0d_diff_hold", i), diff, vecs[i].diff);
        end

        // start while busy must be ignored
        launch(32'd10, 32'd4, 1'b0);
        dcnt = 0;
        seen = '0;
        for (int i = 2; i <= 16; i++) begin
            @(negedge clk);
            if (i == 3) begin
                a = 32'd100; b = 32'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dcnt++;
                seen = diff;
            end
        end
        check("busy_start_done_count", 32'(dcnt), 32'd1);
        check("busy_start_diff", seen, 32'd6);
        check("busy_start_idle", 32'(busy), 32'd0);

        // back-to-back: start held in the done cycle
        launch(32'd20, 32'd7, 1'b0);
        wait_done(cyc, bcnt);
        check("b2b_first_diff", diff, 32'd13);
        a = 32'd9; b = 32'd9; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_accept_busy", 32'(busy), 32'd1);
        wait_done(cyc, bcnt);
        check("b2b_latency", 32'(cyc), 32'd9);
        check("b2b_diff", diff, 32'd0);
        check("b2b_zero", 32'(zero), 32'd1);

        // asynchronous reset in the middle of RUN cycle 4
        launch(32'd50, 32'd8, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_diff", diff, 32'd0);
        check("arst_zero", 32'(zero), 32'd0);
        check("arst_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("arst_no_done", 32'(dcnt), 32'd0);
        launch(32'd7, 32'd2, 1'b0);
        wait_done(cyc, bcnt);
        check("post_rst_latency", 32'(cyc), 32'd9);
        check("post_rst_diff", diff, 32'd5);
        check("post_rst_bout", 32'(bout), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor32.md
Name: serial_subtractor32

Overview:
- Multi-cycle subtractor: diff = a - b - bin, processed CHUNK bits per clock, LSB chunk first, through a ripple chain of full-subtractor cells.
- Inverse-direction companion to the ALU32 full-adder datapath; serves area-constrained ALU32 configurations where a full-width combinational subtractor is too costly.
- Start/busy/done handshake to the ALU32 control sequencer.

Parameters:
- WIDTH, 32, operand and result width.
- CHUNK, 4, bits processed per RUN cycle; must divide WIDTH (elaboration-time check fails otherwise).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled with start.
- b  input  WIDTH  subtrahend; sampled with start.
- bin  input  1  borrow-in; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result valid from this cycle.
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 iff a < b + bin, unsigned.
- zero  output  1  1 iff diff == 0.

Behaviour:
- Reset: one clock and one asynchronous active-low reset, rst_n. While rst_n is low: state=IDLE; busy, done, diff, bout, zero all 0; internal shift registers, borrow and counter cleared.
- States:
  - IDLE: start=1 at edge t0 loads a/b into shift registers and bin into the borrow register, sets cnt=0, moves to RUN, busy=1.
  - RUN: each edge subtracts the low CHUNK bits with the running borrow, shifts the result chunk into the top of the diff shift register, shifts a/b right by CHUNK and increments cnt.
  - RUN exit: on the edge where cnt reaches N-1 (N = WIDTH/CHUNK), the state goes to IDLE, busy=0, done=1, and diff, bout and zero are registered to the final values.
- Latency: start sampled at edge t0 gives done high for the cycle following edge t0+N (N=8 by default); throughput is one operation per N cycles.
- done is high for exactly one cycle. diff, bout and zero hold until the next accepted start completes.
- diff, bout and zero are not updated mid-operation; intermediate values stay internal.
- start while busy=1 is ignored. The request is not queued and operands are not resampled.
- Back-to-back: start high in the done cycle is accepted (state is already IDLE).
- Wrap-around: modular arithmetic.
  - 0 - 0 - 1 gives all-ones with bout=1.
  - All-ones minus all-ones with bin=0 gives 0, bout=0, zero=1.
- Reset mid-RUN aborts the operation with no done pulse. Outputs return to reset values.

Optional Feature:
- SERIAL_SUB_OVF_EN defined:
  - Adds output port ovf (1 bit, reset 0): signed two's-complement overflow of a - b - bin, i.e. borrow into the MSB XOR bout.
  - Registered with diff on the done edge and held like diff.
- SERIAL_SUB_OVF_EN undefined:
  - Port ovf is absent and no MSB borrow-in tracking logic is built.
  - All other behaviour is identical.

Decomposition:
- Shared package alu32_pkg holds:
  - state encoding typedef (IDLE, RUN);
  - localparam N = WIDTH/CHUNK and counter width clog2(N);
  - default WIDTH/CHUNK constants.
- One natural sub-module: fs_cell, a 1-bit combinational full subtractor.
  - Inputs x, y, bi; outputs d, bo.
  - d = x^y^bi; bo = (~x&y) | (~(x^y)&bi).
  - CHUNK instances are chained by generate.
- Top level holds the FSM, counter, shift registers and output registers.

Test Plan:
- a=5, b=3, bin=0, start 1 cycle -> done in the cycle after edge t0+8; diff=2, bout=0, zero=0; busy high for exactly 8 cycles.
- a=3, b=5, bin=0 -> diff=0xFFFFFFFE, bout=1; with SERIAL_SUB_OVF_EN, ovf=0.
- a=0, b=0, bin=1 -> diff=0xFFFFFFFF, bout=1. Then a=0xFFFFFFFF, b=0xFFFFFFFF, bin=0 -> diff=0, zero=1, bout=0.
- SERIAL_SUB_OVF_EN defined: a=0x80000000, b=1 -> diff=0x7FFFFFFF, ovf=1, bout=0. Then a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, ovf=1, bout=1.
- Handshake:
  - Start op a=10, b=4; pulse start again at RUN cycle 3 with a=100, b=1 -> single done, diff=6.
  - start high in the done cycle with a=9, b=9 -> second done 8 cycles later, diff=0, zero=1.
- Reset: drive rst_n low asynchronously mid-edge during RUN cycle 4 -> outputs 0 immediately, no done pulse. After release, a=7, b=2 -> diff=5, done as normal.
